// File: rtl/mips_multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl_if
// Bundle between the multicycle MIPS control FSM and its shared datapath.
//   master : the controller. It reads opcode/funct/zero/mem_ready and drives
//            every strobe, mux select, the illegal flag, the debug state and
//            the retired-instruction count.
//   slave  : the datapath/memory side, with the directions reversed.
// ----------------------------------------------------------------------------
interface mips_multicycle_ctrl_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               pc_en;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [2:0]         alu_op;
  logic               ext_op;
  logic [1:0]         pc_source;
  logic               illegal;
  logic [3:0]         state;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, ext_op, pc_source,
           illegal, state, instr_count
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, ext_op, pc_source,
           illegal, state, instr_count
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Multicycle MIPS control FSM. It sequences the shared PC/IR/memory/regfile/
// ALU datapath, stalls on mem_ready, traps on unknown opcodes (sticky illegal
// flag) and counts retired instructions.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high. While it is high, all strobes are
//           forced low.
//   bus   : mips_multicycle_ctrl_if.master (decode inputs, strobes, selects,
//           illegal, state, instr_count)
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int COUNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REX    = 4'd6,  S_RWB   = 4'd7,
    S_BRANCH = 4'd8,  S_IEX    = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t               r_state;
  state_t               w_next;
  logic                 r_illegal;
  logic [COUNT_W-1:0]   r_instr_count;
  logic                 w_retire;
  logic                 w_pc_en, w_mem_read, w_mem_write, w_ir_write, w_reg_write;
  logic                 w_imm_ext;
  logic [2:0]           w_imm_op;

  // Immediate-ALU decode is shared by IEX and IWB. The extender is
  // registered, so its mode must not change between the two states.
  always_comb begin
    w_imm_ext = 1'b1;
    w_imm_op  = 3'b000;
    case (bus.opcode)
      OP_ANDI: begin w_imm_ext = 1'b0; w_imm_op = 3'b011; end
      OP_ORI:  begin w_imm_ext = 1'b0; w_imm_op = 3'b100; end
      default: begin w_imm_ext = 1'b1; w_imm_op = 3'b000; end
    endcase
  end

  always_comb begin
    w_next         = S_FETCH;
    w_pc_en        = 1'b0;
    w_mem_read     = 1'b0;
    w_mem_write    = 1'b0;
    w_ir_write     = 1'b0;
    w_reg_write    = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 3'b000;
    bus.ext_op     = 1'b1;
    bus.pc_source  = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read    = 1'b1;
        bus.alu_src_b = 2'b01;
        w_ir_write    = bus.mem_ready;
        w_pc_en       = bus.mem_ready;
        w_next        = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // The branch target PC + (imm<<2) is precomputed here.
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:             w_next = S_MEMADR;
          OP_RTYPE:                 w_next = S_REX;
          OP_BEQ, OP_BNE:           w_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: w_next = S_IEX;
          OP_J:                     w_next = S_JUMP;
          default:                  w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        w_next        = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.i_or_d = 1'b1;
        w_mem_read = 1'b1;
        w_next     = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        bus.mem_to_reg = 1'b1;
        w_reg_write    = 1'b1;
      end
      S_MEMWR: begin
        bus.i_or_d  = 1'b1;
        w_mem_write = 1'b1;
        w_next      = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_REX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 3'b010;
        w_next        = S_RWB;
      end
      S_RWB: begin
        bus.reg_dst = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 3'b001;
        bus.pc_source = 2'b01;
        w_pc_en       = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
      end
      S_IEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.ext_op    = w_imm_ext;
        bus.alu_op    = w_imm_op;
        w_next        = S_IWB;
      end
      S_IWB: begin
        bus.ext_op  = w_imm_ext;
        bus.alu_op  = w_imm_op;
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        bus.pc_source = 2'b10;
        w_pc_en       = 1'b1;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  // An instruction retires on the edge that returns to FETCH from a final state.
  assign w_retire = (w_next == S_FETCH) &&
                    (r_state inside {S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_IWB, S_JUMP});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_illegal     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_retire) r_instr_count <= r_instr_count + 1'b1;
    end
  end

  assign bus.pc_en       = w_pc_en     & ~reset;
  assign bus.mem_read    = w_mem_read  & ~reset;
  assign bus.mem_write   = w_mem_write & ~reset;
  assign bus.ir_write    = w_ir_write  & ~reset;
  assign bus.reg_write   = w_reg_write & ~reset;
  assign bus.illegal     = r_illegal;
  assign bus.state       = r_state;
  assign bus.instr_count = r_instr_count;

endmodule
